// File: rtl/alu_operand_sequencer.sv
// Operand/opcode entry sequencer for the 7-segment ALU display.
// Debounces a step button, captures X, Y, M/c_in in turn, then registers the ALU result.
module alu_operand_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       clock_100Mhz,
  input  logic       reset_n,
  input  logic       btn_step,
  input  logic [3:0] sw,
  input  logic       sw_cin,
  output logic [3:0] X,
  output logic [3:0] Y,
  output logic [3:0] M,
  output logic       c_in,
  output logic [3:0] s,
  output logic       c_out,
  output logic       Control,
  output logic       result_valid,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] LOAD_A  = 3'd0;
  localparam logic [2:0] LOAD_B  = 3'd1;
  localparam logic [2:0] LOAD_OP = 3'd2;
  localparam logic [2:0] COMPUTE = 3'd3;
  localparam logic [2:0] SHOW    = 3'd4;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1;
  logic             sync2;
  logic             db_level;
  logic             step_pulse;
  logic [CNT_W-1:0] db_cnt;
  logic [2:0]       state;
  logic [2:0]       next_state;
  logic             cap_x;
  logic             cap_y;
  logic             cap_op;
  logic             do_compute;
  logic [4:0]       alu_res;

  // Returns {carry, result}; SUB carry is the inverted borrow.
  function automatic logic [4:0] alu_eval(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] op, input logic cin);
    logic [4:0] r;
    r = 5'd0;
    case (op)
      4'd0:    r = {1'b0, a} + {1'b0, b} + {4'd0, cin};
      4'd1:    r = {1'b0, a} + {1'b0, ~b} + 5'd1;
      4'd2:    r = {1'b0, a} + 5'd1;
      4'd3:    r = {(a != 4'd0), a - 4'd1};
      4'd4:    r = {1'b0, a & b};
      4'd5:    r = {1'b0, a | b};
      4'd6:    r = {1'b0, a ^ b};
      4'd7:    r = {1'b0, ~a};
      4'd8:    r = {a[3], a[2:0], cin};
      4'd9:    r = {a[0], cin, a[3:1]};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  // Two-flop synchronizer for the raw button.
  always_ff @(posedge clock_100Mhz) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_step;
      sync2 <= sync1;
    end
  end

  // Debounce: level flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clock_100Mhz) begin
    if (!reset_n) begin
      db_level   <= 1'b0;
      db_cnt     <= '0;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      if (sync2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == CNT_LAST) begin
        db_level   <= sync2;
        db_cnt     <= '0;
        step_pulse <= sync2;
      end else begin
        db_cnt <= db_cnt + CNT_ONE;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clock_100Mhz) begin
    if (!reset_n) begin
      state <= LOAD_A;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; illegal encodings fall back to LOAD_A.
  always_comb begin
    next_state = LOAD_A;
    case (state)
      LOAD_A:  if (step_pulse) next_state = LOAD_B;  else next_state = LOAD_A;
      LOAD_B:  if (step_pulse) next_state = LOAD_OP; else next_state = LOAD_B;
      LOAD_OP: if (step_pulse) next_state = COMPUTE; else next_state = LOAD_OP;
      COMPUTE: next_state = SHOW;
      SHOW:    if (step_pulse) next_state = LOAD_A;  else next_state = SHOW;
      default: next_state = LOAD_A;
    endcase
  end

  // FSM output decode: capture and compute strobes.
  always_comb begin
    cap_x      = 1'b0;
    cap_y      = 1'b0;
    cap_op     = 1'b0;
    do_compute = 1'b0;
    case (state)
      LOAD_A:  cap_x      = step_pulse;
      LOAD_B:  cap_y      = step_pulse;
      LOAD_OP: cap_op     = step_pulse;
      COMPUTE: do_compute = 1'b1;
      default: do_compute = 1'b0;
    endcase
  end

  assign alu_res   = alu_eval(X, Y, M, c_in);
  assign state_dbg = state;

  // Registered operand, result and display-mode outputs.
  always_ff @(posedge clock_100Mhz) begin
    if (!reset_n) begin
      X            <= 4'd0;
      Y            <= 4'd0;
      M            <= 4'd0;
      c_in         <= 1'b0;
      s            <= 4'd0;
      c_out        <= 1'b0;
      Control      <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      if (cap_x)  X <= sw;
      if (cap_y)  Y <= sw;
      if (cap_op) begin
        M    <= sw;
        c_in <= sw_cin;
      end
      if (do_compute) begin
        c_out <= alu_res[4];
        s     <= alu_res[3:0];
      end
      result_valid <= do_compute;
      Control      <= (next_state == SHOW);
    end
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: behavioural reference model checked every cycle,
// plus literal expectations at the end of each directed scenario.
module tb_alu_operand_sequencer;

  localparam int DB = 4;

  logic       clock_100Mhz = 1'b0;
  logic       reset_n      = 1'b0;
  logic       btn_step     = 1'b0;
  logic [3:0] sw           = 4'd0;
  logic       sw_cin       = 1'b0;
  logic [3:0] X, Y, M, s;
  logic       c_in, c_out, Control, result_valid;
  logic [2:0] state_dbg;

  int n_vec  = 0;
  int n_bad  = 0;
  int rv_cnt = 0;
  bit chk_en = 1'b0;

  alu_operand_sequencer #(.DEBOUNCE_CYCLES(DB), .CNT_W(3)) dut (
    .clock_100Mhz(clock_100Mhz), .reset_n(reset_n), .btn_step(btn_step),
    .sw(sw), .sw_cin(sw_cin), .X(X), .Y(Y), .M(M), .c_in(c_in), .s(s),
    .c_out(c_out), .Control(Control), .result_valid(result_valid),
    .state_dbg(state_dbg)
  );

  always #5 clock_100Mhz = ~clock_100Mhz;

  // Reference ALU in plain integer arithmetic; returns carry*16 + result.
  function automatic int alu_ref(input int x, input int y, input int m, input int cin);
    int r;
    case (m)
      0:       r = x + y + cin;
      1:       r = ((x - y + 16) % 16) + ((x >= y) ? 16 : 0);
      2:       r = x + 1;
      3:       r = ((x + 15) % 16) + ((x != 0) ? 16 : 0);
      4:       r = x & y;
      5:       r = x | y;
      6:       r = x ^ y;
      7:       r = 15 - x;
      8:       r = (x * 2) + cin;
      9:       r = (x / 2) + cin * 8 + (x % 2) * 16;
      default: r = 0;
    endcase
    return r;
  endfunction

  // Model state
  logic       m_s1, m_s2, m_lvl, m_pulse, m_cin, m_cout, m_ctrl, m_rv;
  int         m_run;
  logic [2:0] m_state;
  logic [3:0] m_x, m_y, m_m, m_s;
  int         m_res;

  // Behavioural model: button must disagree with the accepted level for DB straight samples.
  always @(posedge clock_100Mhz) begin
    if (!reset_n) begin
      m_s1 <= 1'b0; m_s2 <= 1'b0; m_lvl <= 1'b0; m_pulse <= 1'b0; m_run <= 0;
      m_state <= 3'd0; m_x <= 4'd0; m_y <= 4'd0; m_m <= 4'd0; m_cin <= 1'b0;
      m_s <= 4'd0; m_cout <= 1'b0; m_ctrl <= 1'b0; m_rv <= 1'b0;
    end else begin
      m_s1 <= btn_step;
      m_s2 <= m_s1;
      m_pulse <= 1'b0;
      if (m_s2 == m_lvl) m_run <= 0;
      else if (m_run + 1 == DB) begin
        m_lvl <= m_s2; m_run <= 0; m_pulse <= m_s2;
      end else m_run <= m_run + 1;
      m_rv   <= (m_state == 3'd3);
      m_ctrl <= (m_state == 3'd3) || (m_state == 3'd4 && !m_pulse);
      case (m_state)
        3'd0: if (m_pulse) begin m_x <= sw; m_state <= 3'd1; end
        3'd1: if (m_pulse) begin m_y <= sw; m_state <= 3'd2; end
        3'd2: if (m_pulse) begin m_m <= sw; m_cin <= sw_cin; m_state <= 3'd3; end
        3'd3: begin
          m_res = alu_ref(int'(m_x), int'(m_y), int'(m_m), int'(m_cin));
          m_s    <= 4'(m_res % 16);
          m_cout <= (m_res >= 16);
          m_state <= 3'd4;
        end
        default: if (m_pulse) m_state <= 3'd0;
      endcase
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clock_100Mhz) begin
    if (chk_en) begin
      n_vec++;
      if (result_valid === 1'b1) rv_cnt++;
      if ({X, Y, M, c_in, s, c_out, Control, result_valid, state_dbg} !==
          {m_x, m_y, m_m, m_cin, m_s, m_cout, m_ctrl, m_rv, m_state}) begin
        n_bad++;
        $display("FAIL cycle t=%0t: got X=%h Y=%h M=%h cin=%b s=%h cout=%b ctl=%b rv=%b st=%0d expected X=%h Y=%h M=%h cin=%b s=%h cout=%b ctl=%b rv=%b st=%0d",
                 $time, X, Y, M, c_in, s, c_out, Control, result_valid, state_dbg,
                 m_x, m_y, m_m, m_cin, m_s, m_cout, m_ctrl, m_rv, m_state);
      end
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock_100Mhz);
  endtask

  task automatic press();
    btn_step = 1'b1; tick(8);
    btn_step = 1'b0; tick(8);
  endtask

  task automatic run_op(input logic [3:0] x, input logic [3:0] y, input logic [3:0] m,
                        input logic cin, input logic [3:0] es, input logic ec);
    if (state_dbg == 3'd4) press();
    sw = x; press();
    sw = y; press();
    sw = m; sw_cin = cin; press();
    check("s", {4'd0, s}, {4'd0, es});
    check("c_out", {7'd0, c_out}, {7'd0, ec});
    check("Control", {7'd0, Control}, 8'd1);
    check("state_show", {5'd0, state_dbg}, 8'd4);
  endtask

  initial begin
    tick(3);
    reset_n = 1'b1;
    chk_en = 1'b1;
    tick(1);
    check("rst_state", {5'd0, state_dbg}, 8'd0);
    check("rst_X", {4'd0, X}, 8'd0);
    check("rst_s", {4'd0, s}, 8'd0);
    check("rst_Control", {7'd0, Control}, 8'd0);

    rv_cnt = 0;
    run_op(4'h3, 4'h5, 4'h0, 1'b1, 4'h9, 1'b0);
    check("rv_pulses", 8'(rv_cnt), 8'd1);

    run_op(4'hF, 4'h1, 4'h0, 1'b0, 4'h0, 1'b1);
    run_op(4'h0, 4'h0, 4'h3, 1'b0, 4'hF, 1'b0);
    run_op(4'h0, 4'h1, 4'h1, 1'b0, 4'hF, 1'b0);
    run_op(4'hA, 4'h6, 4'h4, 1'b0, 4'h2, 1'b0);
    run_op(4'hA, 4'h6, 4'h5, 1'b0, 4'hE, 1'b0);
    run_op(4'hA, 4'h6, 4'h7, 1'b0, 4'h5, 1'b0);
    run_op(4'h9, 4'h0, 4'h8, 1'b1, 4'h3, 1'b1);
    run_op(4'h9, 4'h0, 4'hC, 1'b0, 4'h0, 1'b0);
    run_op(4'hA, 4'h6, 4'h6, 1'b0, 4'hC, 1'b0);

    // Leave SHOW: operands and result must hold.
    press();
    check("show_exit_Control", {7'd0, Control}, 8'd0);
    check("show_exit_state", {5'd0, state_dbg}, 8'd0);
    check("hold_X", {4'd0, X}, 8'h0A);
    check("hold_Y", {4'd0, Y}, 8'h06);
    check("hold_M", {4'd0, M}, 8'h06);
    check("hold_s", {4'd0, s}, 8'h0C);

    // Glitches of 1..3 cycles must not advance the FSM.
    sw = 4'h7;
    for (int g = 1; g <= 3; g++) begin
      btn_step = 1'b1; tick(g);
      btn_step = 1'b0; tick(8);
    end
    check("glitch_state", {5'd0, state_dbg}, 8'd0);
    btn_step = 1'b1;
    tick(6);
    check("latency_before", {5'd0, state_dbg}, 8'd0);
    tick(1);
    check("latency_after", {5'd0, state_dbg}, 8'd1);
    check("latency_X", {4'd0, X}, 8'h07);
    tick(43);
    check("held_one_step", {5'd0, state_dbg}, 8'd1);
    btn_step = 1'b0; tick(8);

    // Reset coinciding with the LOAD_OP capture step.
    sw = 4'h2; press();
    check("in_load_op", {5'd0, state_dbg}, 8'd2);
    sw = 4'h5; sw_cin = 1'b1;
    btn_step = 1'b1; tick(6);
    reset_n = 1'b0; tick(1);
    reset_n = 1'b1; btn_step = 1'b0; tick(1);
    check("rst_mid_state", {5'd0, state_dbg}, 8'd0);
    check("rst_mid_M", {4'd0, M}, 8'd0);
    check("rst_mid_cin", {7'd0, c_in}, 8'd0);
    check("rst_mid_X", {4'd0, X}, 8'd0);
    check("rst_mid_Y", {4'd0, Y}, 8'd0);
    tick(8);
    sw = 4'h4; press();
    check("post_rst_X", {4'd0, X}, 8'h04);
    check("post_rst_state", {5'd0, state_dbg}, 8'd1);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
